// File: rtl/print_tx_pkg.sv
// Shared definitions for the print path: 3-bit FSM encoding and ASCII constants.
// Also used by the receive-side parser, so keep values stable.
package print_tx_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_CHAR = 3'd2;
   localparam logic [2:0] ST_CR   = 3'd3;
   localparam logic [2:0] ST_LF   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic [7:0] ASC_CR   = 8'h0D;
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_DIG0 = 8'h30;
   localparam logic [7:0] ASC_HEXA = 8'h37;  // 'A' - 10

endpackage

// File: rtl/print_tx_hex2asc.sv
// Nibble to uppercase ASCII hex digit; purely combinational, zero latency.
// No flow control.
module hex2asc
   import print_tx_pkg::*;
(
   input  logic [3:0] nib,
   output logic [7:0] asc
);

   always_comb begin
      if (nib < 4'd10) asc = ASC_DIG0 + {4'b0000, nib};
      else             asc = ASC_HEXA + {4'b0000, nib};
   end

endmodule

// File: rtl/print_tx.sv
// Serialises a captured byte or a hex word (plus optional CR/LF) to a UART tx.
// First char one cycle after LOAD, then one char per cycle; d_tx/vld_tx hold while rdy_tx=0.
module print_tx
   import print_tx_pkg::*;
#(
   parameter int NDIG = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_tx,
   input  logic        type_tx,
   input  logic        crlf_tx,
   input  logic [31:0] dout_tx,
   output logic        ack_tx,
   output logic        flag_tx,
   output logic [7:0]  d_tx,
   output logic        vld_tx,
   input  logic        rdy_tx
);

   localparam logic [3:0] LAST = 4'(NDIG - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [31:0] dat_q,   dat_d;
   logic        typ_q,   typ_d;
   logic        crlf_q,  crlf_d;
   logic [7:0]  d_q,     d_d;
   logic        vld_q,   vld_d;
   logic        ack_q,   ack_d;
   logic        flag_q,  flag_d;

   logic [3:0]  nib_idx;
   logic [3:0]  nib;
   logic [7:0]  hex_chr;
   logic        sent;

   // In LOAD the first (top) nibble is needed; in CHAR the one after the current.
   always_comb begin
      nib_idx = (state_q == ST_LOAD) ? LAST : (LAST - cnt_q - 4'd1);
      nib     = 4'(dat_q >> {nib_idx, 2'b00});
   end

   hex2asc u_hex2asc (
      .nib (nib),
      .asc (hex_chr)
   );

   assign sent = vld_q & rdy_tx;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;
      typ_d   = typ_q;
      crlf_d  = crlf_q;
      d_d     = d_q;
      vld_d   = vld_q;
      ack_d   = 1'b0;
      flag_d  = flag_q;
      case (state_q)
         ST_IDLE: begin
            if (req_tx) begin
               dat_d   = dout_tx;
               typ_d   = type_tx;
               crlf_d  = crlf_tx;
               flag_d  = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            d_d     = typ_q ? hex_chr : dat_q[7:0];
            vld_d   = 1'b1;
            state_d = ST_CHAR;
         end
         ST_CHAR: begin
            if (sent) begin
               if (typ_q && (cnt_q != LAST)) begin
                  cnt_d = cnt_q + 4'd1;
                  d_d   = hex_chr;
               end else if (crlf_q) begin
                  d_d     = ASC_CR;
                  state_d = ST_CR;
               end else begin
                  vld_d   = 1'b0;
                  ack_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_CR: begin
            if (sent) begin
               d_d     = ASC_LF;
               state_d = ST_LF;
            end
         end
         ST_LF: begin
            if (sent) begin
               vld_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            flag_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            vld_d   = 1'b0;
            flag_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         dat_q   <= 32'd0;
         typ_q   <= 1'b0;
         crlf_q  <= 1'b0;
         d_q     <= 8'd0;
         vld_q   <= 1'b0;
         ack_q   <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
         typ_q   <= typ_d;
         crlf_q  <= crlf_d;
         d_q     <= d_d;
         vld_q   <= vld_d;
         ack_q   <= ack_d;
         flag_q  <= flag_d;
      end
   end

   assign d_tx    = d_q;
   assign vld_tx  = vld_q;
   assign ack_tx  = ack_q;
   assign flag_tx = flag_q;

endmodule

// File: tb/tb_print_tx.sv
// Directed bench for print_tx: byte, hex, CR/LF, backpressure, NDIG=2, reset abort, held request.
module tb_print_tx;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, req, type_tx, crlf_tx, rdy_tx, sel;
   logic [31:0] dout_tx;
   logic        req8, req2;
   logic        ack8, flag8, vld8, ack2, flag2, vld2;
   logic [7:0]  d8, d2;
   logic        o_ack, o_flag, o_vld;
   logic [7:0]  o_d;

   assign req8 = req & ~sel;
   assign req2 = req & sel;
   assign o_ack  = sel ? ack2  : ack8;
   assign o_flag = sel ? flag2 : flag8;
   assign o_vld  = sel ? vld2  : vld8;
   assign o_d    = sel ? d2    : d8;

   print_tx #(.NDIG(8)) dut8 (
      .clk(clk), .rstn(rstn), .req_tx(req8), .type_tx(type_tx), .crlf_tx(crlf_tx),
      .dout_tx(dout_tx), .ack_tx(ack8), .flag_tx(flag8), .d_tx(d8), .vld_tx(vld8),
      .rdy_tx(rdy_tx)
   );

   print_tx #(.NDIG(2)) dut2 (
      .clk(clk), .rstn(rstn), .req_tx(req2), .type_tx(type_tx), .crlf_tx(crlf_tx),
      .dout_tx(dout_tx), .ack_tx(ack2), .flag_tx(flag2), .d_tx(d2), .vld_tx(vld2),
      .rdy_tx(rdy_tx)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_c [32];
   int         exp_n;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_exp(input string s, input bit add_crlf);
      exp_n = s.len();
      for (int i = 0; i < exp_n; i++) exp_c[i] = s[i];
      if (add_crlf) begin
         exp_c[exp_n]   = 8'h0D;
         exp_c[exp_n+1] = 8'h0A;
         exp_n += 2;
      end
   endtask

   // Cycle 0 is the IDLE cycle where req is presented; with rdy=1 the ack lands in cycle exp_n+2.
   task automatic do_req(input logic t, input logic c, input logic [31:0] d,
                         input bit throttle, input bit hold, input bit scramble);
      int         idx, ack_k;
      logic       pv, pr;
      logic [7:0] pd;
      bit         done;
      @(negedge clk);
      req = 1'b1; type_tx = t; crlf_tx = c; dout_tx = d; rdy_tx = 1'b1;
      idx = 0; pv = 1'b0; pr = 1'b0; pd = 8'd0; done = 1'b0; ack_k = -1;
      for (int k = 1; k <= 200 && !done; k++) begin
         @(negedge clk);
         if (scramble && k == 2) begin
            dout_tx = ~d; type_tx = ~t; crlf_tx = ~c;
         end
         rdy_tx = throttle ? (k % 3 == 0) : 1'b1;
         if (k == 1) chk("load_vld", o_vld, 0);
         chk("busy_flag", o_flag, 1);
         if (pv && !pr) begin
            chk("hold_vld", o_vld, 1);
            chk("hold_dat", o_d, pd);
         end
         if (!throttle && idx > 0 && idx < exp_n) chk("b2b_vld", o_vld, 1);
         if (o_ack) begin
            done  = 1'b1;
            ack_k = k;
            chk("ack_vld", o_vld, 0);
            if (!hold) req = 1'b0;
         end else if (o_vld && rdy_tx) begin
            if (idx < exp_n) chk($sformatf("char%0d", idx), o_d, exp_c[idx]);
            else             chk("extra_char", idx, exp_n - 1);
            idx++;
         end
         pv = o_vld; pr = rdy_tx; pd = o_d;
      end
      chk("ack_seen", done, 1);
      chk("nchars", idx, exp_n);
      if (!throttle) chk("ack_cycle", ack_k, exp_n + 2);
      if (!hold) begin
         @(negedge clk);
         chk("idle_flag", o_flag, 0);
         chk("idle_ack", o_ack, 0);
         chk("idle_vld", o_vld, 0);
      end
   endtask

   initial begin
      int   got;
      logic seen;
      rstn = 1'b0; req = 1'b0; sel = 1'b0; type_tx = 1'b0; crlf_tx = 1'b0;
      dout_tx = 32'd0; rdy_tx = 1'b0;
      #1;
      chk("rst_vld", o_vld, 0);
      chk("rst_ack", o_ack, 0);
      chk("rst_flag", o_flag, 0);
      chk("rst_d", o_d, 8'h00);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      set_exp("A", 1'b0);
      do_req(1'b0, 1'b0, 32'h0000_0041, 1'b0, 1'b0, 1'b0);

      set_exp("1234ABCD", 1'b1);
      do_req(1'b1, 1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 1'b0);

      do_req(1'b1, 1'b1, 32'h1234_ABCD, 1'b1, 1'b0, 1'b0);

      sel = 1'b1;
      set_exp("0F", 1'b0);
      do_req(1'b1, 1'b0, 32'hFFFF_FF0F, 1'b0, 1'b0, 1'b0);
      sel = 1'b0;

      // Abort in the middle of a word: reset right after the third char is taken.
      @(negedge clk);
      req = 1'b1; type_tx = 1'b1; crlf_tx = 1'b0; dout_tx = 32'h1234_ABCD; rdy_tx = 1'b1;
      got = 0;
      for (int k = 0; k < 20 && got < 3; k++) begin
         @(negedge clk);
         if (o_vld && rdy_tx) got++;
      end
      chk("rst_pre_chars", got, 3);
      @(posedge clk);
      #2;
      rstn = 1'b0; req = 1'b0;
      #1;
      chk("abort_vld", o_vld, 0);
      chk("abort_ack", o_ack, 0);
      chk("abort_flag", o_flag, 0);
      chk("abort_d", o_d, 8'h00);
      @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | o_ack | o_vld | o_flag;
      end
      chk("abort_quiet", seen, 0);
      set_exp("00000000", 1'b0);
      do_req(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

      // Held request restarts immediately; input changes while busy are ignored.
      set_exp("00C0FFEE", 1'b0);
      do_req(1'b1, 1'b0, 32'h00C0_FFEE, 1'b0, 1'b1, 1'b0);
      do_req(1'b1, 1'b0, 32'h00C0_FFEE, 1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
